mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Sits between the MIPS5 core and the single-port memory/bus fabric (downstream of the core).
//  Merges the core's instruction-fetch and data-access requests onto one Avalon-style port.
//  Drives a stall to the core while any access is outstanding.
//  Returns read data with a one-cycle valid pulse.
// PARAMETERS
//  TIMEOUT   0   max waitrequest cycles before abort; 0 = never abort
// PORTS
//  clk           in   1   clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  i_req         in   1   fetch request, level, held until i_valid
//  i_addr        in   32  fetch byte address
//  i_rdata       out  32  fetched instruction, registered
//  i_valid       out  1   1-cycle pulse: i_rdata valid
//  d_read        in   1   data read request, level, held until d_valid
//  d_write       in   1   data write request, level, held until d_valid
//  d_addr        in   32  data byte address
//  d_wdata       in   32  write data
//  d_byteen      in   4   write byte enables
//  d_rdata       out  32  read data, registered
//  d_valid       out  1   1-cycle pulse: data access complete
//  stall         out  1   high while a request is pending or being serviced
//  err           out  1   sticky error flag; cleared only by reset
//  m_address     out  32  bus address, word aligned
//  m_read        out  1   bus read strobe
//  m_write       out  1   bus write strobe
//  m_writedata   out  32  bus write data
//  m_byteenable  out  4   bus byte enables (4'b1111 on reads)
//  m_readdata    in   32  bus read data, valid when strobe=1 and waitrequest=0
//  m_waitrequest in   1   bus not ready; hold strobes and address stable
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, state IDLE
//   - reset asserted mid-transaction drops m_read/m_write immediately
//   - no valid pulse is produced for an aborted transaction
//  States: IDLE -> DATA | FETCH -> RESP -> IDLE.
//  IDLE:
//   - sample requests at the edge
//   - data (d_read|d_write) has priority over i_req when both are high
//   - the request is latched (addr, wdata, byteen, kind); bus strobe goes high the next cycle
//  DATA/FETCH:
//   - strobe and all m_* outputs held constant while m_waitrequest=1
//   - completion edge = first edge with strobe=1 and m_waitrequest=0
//   - at completion: capture m_readdata (reads only), drop strobe, go to RESP
//  RESP:
//   - i_valid or d_valid = 1 for exactly this cycle
//   - requests are ignored; core must deassert or change its request by the next edge
//  Latency: request edge -> strobe +1 cycle; zero-wait bus gives valid 2 cycles after request sample.
//  stall = (any request high & not RESP) | (state != IDLE & state != RESP).
//  d_read & d_write both high: treated as write; err set.
//  Misaligned access (addr[1:0] != 0, fetch or data):
//   - no bus cycle is issued
//   - go straight to RESP with rdata = 0
//   - err set
//  Timeout (TIMEOUT > 0):
//   - wait counter counts strobe cycles with waitrequest=1
//   - on reaching TIMEOUT: drop strobe, rdata = 0, err set, go to RESP
//   - counter clears every transaction
//  Addresses pass through unmodified; no byte lane shifting (handled by core).
//  m_read and m_write are never high together; both are low in IDLE and RESP.
// TESTING
//  1. Fetch 0xBFC00000, waitrequest high 2 cycles, readdata 0x8C090008
//     -> m_read high exactly 3 cycles; i_rdata = 0x8C090008; i_valid one pulse; stall low after RESP.
//  2. d_read addr 8, zero wait, readdata 4985
//     -> d_rdata = 4985; d_valid at cycle +2; m_byteenable = 4'b1111.
//  3. d_write and i_req raised same cycle; addr 0x10, wdata 0xDEADBEEF, byteen 4'b0011
//     -> write issued first with those values; fetch follows after RESP; both valids pulse once, in order.
//  4. d_read addr 0x6 -> no m_read; d_valid pulse; d_rdata = 0; err = 1 and stays 1.
//  5. TIMEOUT = 4, waitrequest stuck high
//     -> m_read high 4 cycles then low; d_valid pulse; d_rdata = 0; err = 1.
//  6. reset asserted during waitrequest stall
//     -> m_read falls without a clock edge; no valid pulse; a fresh fetch after release completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the core, the fetch/data arbiter and the single-port memory bus.
// Modport master is the arbiter's view; modport slave is the core-and-memory environment.
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        stall;
  logic        err;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_waitrequest;

  modport master (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteen,
           m_readdata, m_waitrequest,
    output i_rdata, i_valid, d_rdata, d_valid, stall, err,
           m_address, m_read, m_write, m_writedata, m_byteenable
  );

  modport slave (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteen,
           m_readdata, m_waitrequest,
    input  i_rdata, i_valid, d_rdata, d_valid, stall, err,
           m_address, m_read, m_write, m_writedata, m_byteenable
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Merges instruction fetch and data accesses onto one Avalon-style port, one access at a time.
// Valid/ready: a core request is a level held until its 1-cycle valid; a bus strobe completes on the first edge with waitrequest low.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.master  bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          write_q, write_d;
  logic          fetch_q, fetch_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          err_q, err_d;

  logic        any_req;
  logic        data_req;
  logic [31:0] req_addr;
  logic        strobe;
  logic        timed_out;

  assign data_req  = bus.d_read | bus.d_write;
  assign any_req   = bus.i_req | data_req;
  assign req_addr  = data_req ? bus.d_addr : bus.i_addr;
  assign strobe    = (state_q == DATA) || (state_q == FETCH);
  // Abort on the edge that would be the TIMEOUT-th stalled strobe cycle.
  assign timed_out = (TIMEOUT > 0) && strobe && bus.m_waitrequest &&
                     (wait_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      write_q   <= 1'b0;
      fetch_q   <= 1'b0;
      wait_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      write_q   <= write_d;
      fetch_q   <= fetch_d;
      wait_q    <= wait_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    write_d   = write_q;
    fetch_d   = fetch_q;
    wait_d    = wait_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        wait_d = '0;
        if (any_req) begin
          fetch_d = !data_req;
          write_d = bus.d_write;
          addr_d  = req_addr;
          wdata_d = bus.d_wdata;
          be_d    = bus.d_byteen;
          if (bus.d_read && bus.d_write) err_d = 1'b1;
          // Misaligned accesses never reach the bus and answer with zero data.
          if (req_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = RESP;
            if (data_req) d_rdata_d = '0;
            else          i_rdata_d = '0;
          end else begin
            state_d = data_req ? DATA : FETCH;
          end
        end
      end
      DATA, FETCH: begin
        if (!bus.m_waitrequest) begin
          state_d = RESP;
          if (fetch_q)       i_rdata_d = bus.m_readdata;
          else if (!write_q) d_rdata_d = bus.m_readdata;
        end else if (timed_out) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (fetch_q) i_rdata_d = '0;
          else         d_rdata_d = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.m_read       = strobe && !write_q;
  assign bus.m_write      = strobe && write_q;
  assign bus.m_address    = strobe ? addr_q : 32'd0;
  assign bus.m_writedata  = (strobe && write_q) ? wdata_q : 32'd0;
  assign bus.m_byteenable = strobe ? (write_q ? be_q : 4'b1111) : 4'b0000;

  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_valid = (state_q == RESP) && fetch_q;
  assign bus.d_valid = (state_q == RESP) && !fetch_q;
  assign bus.err     = err_q;
  assign bus.stall   = !reset && ((any_req && (state_q != RESP)) || strobe);

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level model predicts bus strobes, latency,
// response data and the sticky error flag; a per-cycle monitor checks the bus and handshake against it.
module tb_mem_bus_arbiter;
  localparam int T = 4;
  localparam int W = 35;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // {is_fetch, err_after, rdata_checked, rdata}
  logic [W-1:0] exp_q[$];

  bit          tb_active   = 1'b0;
  int          strobe_seen = 0;
  int          resp_cnt    = 0;
  int          wait_n      = 0;
  logic [31:0] rd_value    = 32'd0;
  logic [31:0] cur_addr    = 32'd0;
  logic [31:0] cur_wdata   = 32'd0;
  logic [3:0]  cur_be      = 4'd0;
  bit          cur_write   = 1'b0;
  bit          err_model   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: holds waitrequest for wait_n strobe cycles, junk data while waiting.
  always @(negedge clk) begin
    if (bus.m_read || bus.m_write) begin
      bus.m_waitrequest = (resp_cnt < wait_n);
      bus.m_readdata    = bus.m_waitrequest ? $urandom : rd_value;
      resp_cnt++;
    end else begin
      bus.m_waitrequest = 1'($urandom_range(0, 1));
      bus.m_readdata    = $urandom;
    end
  end

  // Per-cycle compare process.
  bit err_prev = 1'b0;
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      check("strobe_exclusive", 32'(bus.m_read & bus.m_write), 32'd0);
      if (bus.m_read || bus.m_write) begin
        strobe_seen++;
        check("strobe_owner", 32'(tb_active), 32'd1);
        check("m_address", bus.m_address, cur_addr);
        check("m_write", 32'(bus.m_write), 32'(cur_write));
        check("m_byteenable", 32'(bus.m_byteenable), cur_write ? 32'(cur_be) : 32'hF);
        if (cur_write) check("m_writedata", bus.m_writedata, cur_wdata);
      end
      check("stall", 32'(bus.stall), 32'(tb_active && !(bus.i_valid || bus.d_valid)));
      if (bus.i_valid || bus.d_valid) begin
        check("valid_exclusive", 32'(bus.i_valid & bus.d_valid), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got i_valid=%0b d_valid=%0b expected none", bus.i_valid, bus.d_valid);
        end else begin
          e = exp_q.pop_front();
          check("valid_is_fetch", 32'(bus.i_valid), 32'(e[34]));
          check("err_at_valid", 32'(bus.err), 32'(e[33]));
          if (e[32]) check("rdata", bus.i_valid ? bus.i_rdata : bus.d_rdata, e[31:0]);
        end
      end
      if (!reset && err_prev) check("err_sticky", 32'(bus.err), 32'd1);
      err_prev = bus.err;
    end
  end

  // One core access; starts at a negedge with the arbiter idle (or in RESP when queued=1).
  task automatic run_txn(input bit fetch, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input int wn, input logic [31:0] rdv, input bit queued, input bit hold_fetch,
                         output int lat, output int strobes);
    bit mis, to, chk;
    int exp_strobe, exp_lat, n;
    logic [31:0] exp_rd;
    mis        = (addr[1:0] != 2'b00);
    to         = !mis && (wn >= T);
    exp_strobe = mis ? 0 : (to ? T : wn + 1);
    exp_lat    = 1 + exp_strobe + (queued ? 1 : 0);
    err_model  = err_model | mis | (rd & wr) | to;
    chk        = mis || to || !wr;
    exp_rd     = (mis || to) ? 32'd0 : rdv;
    exp_q.push_back({fetch, err_model, chk, exp_rd});
    cur_addr    = addr;
    cur_write   = wr;
    cur_wdata   = wdata;
    cur_be      = be;
    wait_n      = wn;
    rd_value    = rdv;
    resp_cnt    = 0;
    strobe_seen = 0;
    tb_active   = 1'b1;
    if (fetch) begin
      bus.i_req   = 1'b1;
      bus.i_addr  = addr;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      bus.d_addr  = $urandom;
    end else begin
      bus.i_req    = hold_fetch;
      bus.d_read   = rd;
      bus.d_write  = wr;
      bus.d_addr   = addr;
      bus.d_wdata  = wdata;
      bus.d_byteen = be;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.i_valid || bus.d_valid) && n < 40);
    if (!(bus.i_valid || bus.d_valid)) begin
      checks++;
      errors++;
      $display("FAIL valid_wait: got no valid after %0d cycles expected latency %0d", n, exp_lat);
    end
    lat     = n;
    strobes = strobe_seen;
    check("latency", 32'(n), 32'(exp_lat));
    check("strobe_cycles", 32'(strobe_seen), 32'(exp_strobe));
    bus.i_req   = hold_fetch;
    bus.d_read  = 1'b0;
    bus.d_write = 1'b0;
    tb_active   = 1'b0;
    if (!hold_fetch) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stb, kind, wn;
    logic [31:0] addr, rdv;
    bit rd, wr, fe;

    reset        = 1'b1;
    bus.i_req    = 1'b0;
    bus.i_addr   = 32'd0;
    bus.d_read   = 1'b0;
    bus.d_write  = 1'b0;
    bus.d_addr   = 32'd0;
    bus.d_wdata  = 32'd0;
    bus.d_byteen = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_i_valid", 32'(bus.i_valid), 32'd0);
    check("rst_d_valid", 32'(bus.d_valid), 32'd0);
    check("rst_i_rdata", bus.i_rdata, 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_m_read", 32'(bus.m_read), 32'd0);
    check("rst_m_write", 32'(bus.m_write), 32'd0);
    check("rst_m_address", bus.m_address, 32'd0);
    check("rst_m_byteenable", 32'(bus.m_byteenable), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch with two wait cycles.
    run_txn(1, 0, 0, 32'hBFC00000, 32'd0, 4'd0, 2, 32'h8C090008, 0, 0, lat, stb);
    check("t1_m_read_cycles", 32'(stb), 32'd3);
    check("t1_i_rdata", bus.i_rdata, 32'h8C090008);
    check("t1_stall_after", 32'(bus.stall), 32'd0);

    // Zero-wait data read.
    run_txn(0, 1, 0, 32'd8, 32'd0, 4'd0, 0, 32'd4985, 0, 0, lat, stb);
    check("t2_latency", 32'(lat), 32'd2);
    check("t2_d_rdata", bus.d_rdata, 32'd4985);

    // Write and fetch raised together: write first, fetch after RESP.
    bus.i_addr = 32'h00000400;
    run_txn(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'b0011, 0, 32'd0, 0, 1, lat, stb);
    check("t3_write_cycles", 32'(stb), 32'd1);
    run_txn(1, 0, 0, 32'h00000400, 32'd0, 4'd0, 0, 32'h12345678, 1, 0, lat, stb);
    check("t3_fetch_latency", 32'(lat), 32'd3);
    check("t3_i_rdata", bus.i_rdata, 32'h12345678);
    check("t3_err_clean", 32'(bus.err), 32'd0);

    // Misaligned read.
    run_txn(0, 1, 0, 32'h6, 32'd0, 4'd0, 0, 32'hCAFEF00D, 0, 0, lat, stb);
    check("t4_m_read_cycles", 32'(stb), 32'd0);
    check("t4_d_rdata", bus.d_rdata, 32'd0);
    repeat (3) @(negedge clk);
    check("t4_err_stays", 32'(bus.err), 32'd1);

    // Stuck waitrequest aborts after TIMEOUT strobe cycles.
    run_txn(0, 1, 0, 32'h20, 32'd0, 4'd0, 50, 32'h55AA55AA, 0, 0, lat, stb);
    check("t5_m_read_cycles", 32'(stb), 32'd4);
    check("t5_d_rdata", bus.d_rdata, 32'd0);
    check("t5_err", 32'(bus.err), 32'd1);

    // Randomized mix of fetches, reads, writes, conflicts, misalignment and waits.
    for (int k = 0; k < 80; k++) begin
      kind = $urandom_range(0, 9);
      fe   = (kind <= 3);
      rd   = (kind >= 4 && kind <= 6) || kind == 9;
      wr   = (kind >= 7);
      addr = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wn   = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 5);
      rdv  = $urandom;
      run_txn(fe, rd, wr, addr, $urandom, 4'($urandom_range(0, 15)), wn, rdv, 0, 0, lat, stb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during a waitrequest stall.
    cur_addr    = 32'h00001000;
    cur_write   = 1'b0;
    wait_n      = 100;
    resp_cnt    = 0;
    strobe_seen = 0;
    tb_active   = 1'b1;
    bus.i_addr  = 32'h00001000;
    bus.i_req   = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_m_read_before", 32'(bus.m_read), 32'd1);
    #2;
    reset     = 1'b1;
    bus.i_req = 1'b0;
    tb_active = 1'b0;
    exp_q.delete();
    err_model = 1'b0;
    #1;
    check("t6_m_read_drop", 32'(bus.m_read), 32'd0);
    check("t6_state_idle", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("t6_err_cleared", 32'(bus.err), 32'd0);
    repeat (3) @(negedge clk);
    run_txn(1, 0, 0, 32'h00002000, 32'd0, 4'd0, 1, 32'h0BADC0DE, 0, 0, lat, stb);
    check("t6_fresh_latency", 32'(lat), 32'd3);
    check("t6_fresh_i_rdata", bus.i_rdata, 32'h0BADC0DE);

    repeat (4) @(negedge clk);
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
